// File: rtl/mac_dot_sequencer.sv
// ---------------------------------------------------------------------------
// mac_dot_sequencer
//
// Upstream controller for a 16-bit Q9.6 multiply-accumulate stage computing
// D0 = ((S0*S1)>>6) + S2. A stream of (x, w) operand pairs is issued to the
// MAC one term at a time. Each returned partial sum becomes the S2 operand of
// the next term, so a LEN-term dot product plus bias is built up serially.
// The final sum is presented on a ready/valid result port.
//
// Optional feature macro: MAC_SEQ_RELU_EN
//   defined   : res_data = (acc < 0) ? 0 : acc
//   undefined : res_data = acc (raw signed value, no clamp logic)
//
// Ports
//   CLK, RST_N          clock (rising edge), asynchronous active-low reset
//   start, len, bias    begin a dot product (sampled in IDLE only)
//   op_valid/op_ready   operand pair handshake, op_x -> S0, op_w -> S1
//   mac_valid           one-cycle issue strobe for S0/S1/S2
//   mac_s0/s1/s2        MAC operands, held until the next issue
//   mac_d_valid, mac_d  MAC result return
//   res_valid/res_ready result handshake, res_data final sum
//   res_err             result produced by a watchdog abort
//   busy                high in every state except IDLE
// ---------------------------------------------------------------------------
module mac_dot_sequencer #(
    parameter int unsigned WORD_BITS = 16,
    parameter int unsigned LEN_BITS  = 8,
    parameter int unsigned TO_CYCLES = 15
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 start,
    input  logic [LEN_BITS-1:0]  len,
    input  logic [WORD_BITS-1:0] bias,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [WORD_BITS-1:0] op_x,
    input  logic [WORD_BITS-1:0] op_w,
    output logic                 mac_valid,
    output logic [WORD_BITS-1:0] mac_s0,
    output logic [WORD_BITS-1:0] mac_s1,
    output logic [WORD_BITS-1:0] mac_s2,
    input  logic                 mac_d_valid,
    input  logic [WORD_BITS-1:0] mac_d,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [WORD_BITS-1:0] res_data,
    output logic                 res_err,
    output logic                 busy
);

    localparam int unsigned WD_BITS = $clog2(TO_CYCLES + 1);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StWait,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [LEN_BITS-1:0]  len_q, len_d;
    logic [LEN_BITS-1:0]  cnt_q, cnt_d;
    logic [WORD_BITS-1:0] acc_q, acc_d;
    logic [WD_BITS-1:0]   wd_q, wd_d;

    logic                 op_ready_q, op_ready_d;
    logic                 mac_valid_q, mac_valid_d;
    logic [WORD_BITS-1:0] mac_s0_q, mac_s0_d;
    logic [WORD_BITS-1:0] mac_s1_q, mac_s1_d;
    logic [WORD_BITS-1:0] mac_s2_q, mac_s2_d;
    logic                 res_valid_q, res_valid_d;
    logic [WORD_BITS-1:0] res_data_q, res_data_d;
    logic                 res_err_q, res_err_d;
    logic                 busy_q, busy_d;

    // Output formatting of the accumulator onto res_data.
    function automatic logic [WORD_BITS-1:0] res_fmt(input logic [WORD_BITS-1:0] v);
`ifdef MAC_SEQ_RELU_EN
        return v[WORD_BITS-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        wd_d        = wd_q;
        op_ready_d  = op_ready_q;
        mac_valid_d = 1'b0;
        mac_s0_d    = mac_s0_q;
        mac_s1_d    = mac_s1_q;
        mac_s2_d    = mac_s2_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;
        busy_d      = busy_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d  = len;
                    acc_d  = bias;
                    cnt_d  = '0;
                    wd_d   = '0;
                    busy_d = 1'b1;
                    if (len != '0) begin
                        state_d    = StFetch;
                        op_ready_d = 1'b1;
                    end else begin
                        // Empty product: result is just the bias.
                        state_d     = StDone;
                        res_valid_d = 1'b1;
                        res_data_d  = res_fmt(bias);
                    end
                end
            end

            StFetch: begin
                if (op_valid && op_ready_q) begin
                    mac_s0_d    = op_x;
                    mac_s1_d    = op_w;
                    mac_s2_d    = acc_q;
                    mac_valid_d = 1'b1;
                    op_ready_d  = 1'b0;
                    wd_d        = '0;
                    state_d     = StWait;
                end
            end

            StWait: begin
                if (mac_d_valid) begin
                    acc_d = mac_d;
                    cnt_d = cnt_q + 1'b1;
                    if (LEN_BITS'(cnt_q + 1'b1) == len_q) begin
                        state_d     = StDone;
                        res_valid_d = 1'b1;
                        res_data_d  = res_fmt(mac_d);
                    end else begin
                        state_d    = StFetch;
                        op_ready_d = 1'b1;
                    end
                end else if (wd_q == WD_BITS'(TO_CYCLES - 1)) begin
                    // MAC never answered: report the partial sum with an error.
                    state_d     = StDone;
                    res_err_d   = 1'b1;
                    res_valid_d = 1'b1;
                    res_data_d  = res_fmt(acc_q);
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end

            StDone: begin
                if (res_ready && res_valid_q) begin
                    res_valid_d = 1'b0;
                    res_err_d   = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            len_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            wd_q        <= '0;
            op_ready_q  <= 1'b0;
            mac_valid_q <= 1'b0;
            mac_s0_q    <= '0;
            mac_s1_q    <= '0;
            mac_s2_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            wd_q        <= wd_d;
            op_ready_q  <= op_ready_d;
            mac_valid_q <= mac_valid_d;
            mac_s0_q    <= mac_s0_d;
            mac_s1_q    <= mac_s1_d;
            mac_s2_q    <= mac_s2_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
            busy_q      <= busy_d;
        end
    end

    assign op_ready  = op_ready_q;
    assign mac_valid = mac_valid_q;
    assign mac_s0    = mac_s0_q;
    assign mac_s1    = mac_s1_q;
    assign mac_s2    = mac_s2_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mac_dot_sequencer
//
// Directed bench for mac_dot_sequencer with a 2-cycle MAC model
// (D0 = ((S0*S1)>>>6) + S2). The model can drop one chosen issue to exercise
// the watchdog, and is deliberately not reset so a result in flight across a
// sequencer reset still arrives late.
// ---------------------------------------------------------------------------
module tb_mac_dot_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        start;
    logic [7:0]  len;
    logic [15:0] bias;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_x;
    logic [15:0] op_w;
    logic        mac_valid;
    logic [15:0] mac_s0;
    logic [15:0] mac_s1;
    logic [15:0] mac_s2;
    logic        mac_d_valid = 1'b0;
    logic [15:0] mac_d       = '0;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    mac_dot_sequencer dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .start       (start),
        .len         (len),
        .bias        (bias),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_x        (op_x),
        .op_w        (op_w),
        .mac_valid   (mac_valid),
        .mac_s0      (mac_s0),
        .mac_s1      (mac_s1),
        .mac_s2      (mac_s2),
        .mac_d_valid (mac_d_valid),
        .mac_d       (mac_d),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_err     (res_err),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    // ---------------- MAC model ----------------
    logic        s1_v = 1'b0;
    logic [15:0] s1_d = '0;
    int          mac_pulses = 0;
    int          drop_at    = -1;
    logic [15:0] s2_log [64];

    function automatic logic [15:0] mac_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] c);
        logic signed [31:0] ea, eb, p, r;
        ea = {{16{a[15]}}, a};
        eb = {{16{b[15]}}, b};
        p  = ea * eb;
        r  = p >>> 6;
        return r[15:0] + c;
    endfunction

    always @(posedge CLK) begin
        s1_v <= 1'b0;
        if (mac_valid) begin
            s1_v                   <= (mac_pulses != drop_at);
            s1_d                   <= mac_fn(mac_s0, mac_s1, mac_s2);
            s2_log[mac_pulses % 64] <= mac_s2;
            mac_pulses             <= mac_pulses + 1;
        end
        mac_d_valid <= s1_v;
        mac_d       <= s1_d;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] l, input logic [15:0] b);
        @(negedge CLK);
        start = 1'b1;
        len   = l;
        bias  = b;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    // Present one operand pair and return just after the accepting edge.
    task automatic feed(input string tag, input logic [15:0] x, input logic [15:0] w);
        logic ok;
        ok       = 1'b0;
        op_x     = x;
        op_w     = w;
        op_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (op_ready) begin
                @(posedge CLK);
                #1;
                ok = 1'b1;
                break;
            end
        end
        op_valid = 1'b0;
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    // Number of clock edges until res_valid is seen, -1 on timeout.
    task automatic wait_res(output int cyc);
        cyc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (res_valid) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic accept();
        @(negedge CLK);
        res_ready = 1'b1;
        @(posedge CLK);
        #1;
        res_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int base;
        logic [15:0] exp2;

        RST_N     = 1'b0;
        start     = 1'b0;
        len       = '0;
        bias      = '0;
        op_valid  = 1'b0;
        op_x      = '0;
        op_w      = '0;
        res_ready = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_op_ready", {31'd0, op_ready}, 32'd0);
        check("rst_mac_valid", {31'd0, mac_valid}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_data", {16'd0, res_data}, 32'd0);
        check("rst_res_err", {31'd0, res_err}, 32'd0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        // 1: three-term dot product with bias 0.25
        base = mac_pulses;
        do_start(8'd3, 16'h0010);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_op_ready", {31'd0, op_ready}, 32'd1);
        feed("t1_feed0", 16'h0040, 16'h0080);
        feed("t1_feed1", 16'h0080, 16'h0020);
        feed("t1_feed2", 16'hFFE0, 16'h0100);
        wait_res(cyc);
        check("t1_latency", cyc, 32'd3);
        check("t1_data", {16'd0, res_data}, 32'h0050);
        check("t1_err", {31'd0, res_err}, 32'd0);
        check("t1_s2_0", {16'd0, s2_log[base % 64]}, 32'h0010);
        check("t1_s2_1", {16'd0, s2_log[(base + 1) % 64]}, 32'h0090);
        check("t1_s2_2", {16'd0, s2_log[(base + 2) % 64]}, 32'h00D0);
        accept();
        @(negedge CLK);
        check("t1_idle_res_valid", {31'd0, res_valid}, 32'd0);
        check("t1_idle_busy", {31'd0, busy}, 32'd0);

        // 2: single negative term, clamp depends on build
`ifdef MAC_SEQ_RELU_EN
        exp2 = 16'h0000;
`else
        exp2 = 16'hFFC0;
`endif
        do_start(8'd1, 16'hFFC0);
        feed("t2_feed0", 16'h0000, 16'h0000);
        wait_res(cyc);
        check("t2_seen", {31'd0, cyc >= 0}, 32'd1);
        check("t2_data", {16'd0, res_data}, {16'd0, exp2});
        check("t2_err", {31'd0, res_err}, 32'd0);
        accept();

        // 3: zero-length product
        base = mac_pulses;
        @(negedge CLK);
        start = 1'b1;
        len   = 8'd0;
        bias  = 16'h0123;
        @(posedge CLK);
        #1;
        start = 1'b0;
        check("t3_res_valid", {31'd0, res_valid}, 32'd1);
        check("t3_data", {16'd0, res_data}, 32'h0123);
        check("t3_mac_valid", {31'd0, mac_valid}, 32'd0);

        // 4: back-pressure in DONE with a stray start
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            start = (i == 2);
            len   = 8'd5;
            bias  = 16'h7777;
            check("t4_res_valid", {31'd0, res_valid}, 32'd1);
            check("t4_data", {16'd0, res_data}, 32'h0123);
        end
        start = 1'b0;
        accept();
        @(negedge CLK);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_res_valid", {31'd0, res_valid}, 32'd0);
        check("t4_op_ready", {31'd0, op_ready}, 32'd0);
        check("t4_no_issue", mac_pulses - base, 32'd0);

        // 5: MAC drops term 2 of 4 -> watchdog abort with term-1 sum
        drop_at = mac_pulses + 1;
        do_start(8'd4, 16'h0000);
        feed("t5_feed0", 16'h0040, 16'h0040);
        feed("t5_feed1", 16'h0040, 16'h0040);
        wait_res(cyc);
        check("t5_timeout_cycles", cyc, 32'd15);
        check("t5_data", {16'd0, res_data}, 32'h0040);
        check("t5_err", {31'd0, res_err}, 32'd1);
        accept();
        drop_at = -1;
        @(negedge CLK);
        check("t5_err_clear", {31'd0, res_err}, 32'd0);

        // 6: reset while a MAC result is in flight
        do_start(8'd2, 16'h0000);
        feed("t6_feed0", 16'h0040, 16'h0040);
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_mac_valid", {31'd0, mac_valid}, 32'd0);
        check("t6_rst_mac_s0", {16'd0, mac_s0}, 32'd0);
        check("t6_rst_res_data", {16'd0, res_data}, 32'd0);
        check("t6_rst_op_ready", {31'd0, op_ready}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check("t6_late_busy", {31'd0, busy}, 32'd0);
        check("t6_late_res_valid", {31'd0, res_valid}, 32'd0);
        check("t6_late_op_ready", {31'd0, op_ready}, 32'd0);
        do_start(8'd1, 16'h0010);
        feed("t6_feed1", 16'h0040, 16'h0080);
        wait_res(cyc);
        check("t6_latency", cyc, 32'd3);
        check("t6_data", {16'd0, res_data}, 32'h0090);
        check("t6_err", {31'd0, res_err}, 32'd0);
        accept();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
